// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state type, port indices and default starvation limit
// for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        DBG,
        DBG_LOCK
    } arb_state_e;

    localparam logic PORT_CPU     = 1'b0;
    localparam logic PORT_DBG     = 1'b1;
    localparam int   MAX_WAIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_rtag.sv
// dmem_arb_rtag: two-stage read-tag pipeline (valid + owner) that steers the
// 1-cycle-latency memory read data back to the port that issued the read.
module dmem_arb_rtag
    import dmem_arb_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_i,
    input  logic          owner_i,
    input  logic [DW-1:0] m_rdata_i,
    output logic          c_rvalid_o,
    output logic [DW-1:0] c_rdata_o,
    output logic          d_rvalid_o,
    output logic [DW-1:0] d_rdata_o
);

    logic          v1_q, o1_q, v2_q, o2_q;
    logic [DW-1:0] c_rd_q, d_rd_q;

    // Stage 1 lines up with m_en, stage 2 with the cycle m_rdata is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            o1_q   <= PORT_CPU;
            v2_q   <= 1'b0;
            o2_q   <= PORT_CPU;
            c_rd_q <= '0;
            d_rd_q <= '0;
        end else begin
            v1_q <= issue_i;
            o1_q <= owner_i;
            v2_q <= v1_q;
            o2_q <= o1_q;
            if (c_rvalid_o) c_rd_q <= m_rdata_i;
            if (d_rvalid_o) d_rd_q <= m_rdata_i;
        end
    end

    assign c_rvalid_o = v2_q && (o2_q == PORT_CPU);
    assign d_rvalid_o = v2_q && (o2_q == PORT_DBG);
    assign c_rdata_o  = c_rvalid_o ? m_rdata_i : c_rd_q;
    assign d_rdata_o  = d_rvalid_o ? m_rdata_i : d_rd_q;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU / debug-loader arbiter onto one clocked data memory with
// locked loader bursts and a starvation guard; DMEM_ARB_STATS_EN adds grant stats.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_lock,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_c_cnt,
    output logic [31:0]   stat_d_cnt,
    output logic          stat_force
`endif
);

    localparam int            WW       = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

    arb_state_e    state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          locked, starve, c_win, d_win;
    logic          m_en_q, m_we_q, c_gnt_q, d_gnt_q;
    logic [AW-1:0] m_addr_q;
    logic [DW-1:0] m_wdata_q;

    // A starved debug request overrides the CPU once; a lock shuts the CPU out.
    always_comb begin
        locked  = state_q == DBG_LOCK;
        starve  = (wcnt_q == WAIT_MAX) && d_req;
        c_win   = !locked && c_req && !starve;
        d_win   = d_req && !c_win;
        state_d = c_win ? CPU
                : d_win ? (d_lock ? DBG_LOCK : DBG)
                : (locked && d_lock) ? DBG_LOCK : IDLE;
        wcnt_d  = (d_win || !d_req) ? '0
                : (c_win && wcnt_q != WAIT_MAX) ? wcnt_q + WW'(1) : wcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            c_gnt_q   <= 1'b0;
            d_gnt_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            m_en_q    <= c_win || d_win;
            m_we_q    <= c_win ? c_we : (d_win && d_we);
            m_addr_q  <= c_win ? c_addr : d_win ? d_addr : '0;
            m_wdata_q <= c_win ? c_wdata : d_win ? d_wdata : '0;
            c_gnt_q   <= c_win;
            d_gnt_q   <= d_win;
        end
    end

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign c_gnt   = c_gnt_q;
    assign d_gnt   = d_gnt_q;

    dmem_arb_rtag #(.DW(DW)) u_rtag (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_i    ((c_win && !c_we) || (d_win && !d_we)),
        .owner_i    (d_win ? PORT_DBG : PORT_CPU),
        .m_rdata_i  (m_rdata),
        .c_rvalid_o (c_rvalid),
        .c_rdata_o  (c_rdata),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_c_q, stat_d_q;
    logic        force_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_c_q <= '0;
            stat_d_q <= '0;
            force_q  <= 1'b0;
        end else begin
            stat_c_q <= stat_c_q + 32'(c_win);
            stat_d_q <= stat_d_q + 32'(d_win);
            force_q  <= d_win && starve && c_req;
        end
    end

    assign stat_c_cnt = stat_c_q;
    assign stat_d_cnt = stat_d_q;
    assign stat_force = force_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model with its own shadow memory.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          d_req = 1'b0, d_lock = 1'b0, d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, m_en, m_we;
    logic [DW-1:0] c_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0]   stat_c_cnt, stat_d_cnt;
    logic          stat_force;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [16];
    logic          ld = 1'b0;
    logic [3:0]    ld_idx = '0;
    logic [DW-1:0] ld_val = '0;
    logic [133:0]  all_out;

    assign all_out = {c_gnt, c_rvalid, c_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_we, m_addr, m_wdata};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld) mem[ld_idx] <= ld_val;
        else if (m_en && m_we) mem[m_addr[5:2]] <= m_wdata;
        else if (m_en) m_rdata <= mem[m_addr[5:2]];
    end

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_c_cnt(stat_c_cnt), .stat_d_cnt(stat_d_cnt), .stat_force(stat_force)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_lock = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        rst_n = 0;
        repeat (2) tick;
        rst_n = 1;
        tick;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [DW-1:0] v);
        ld = 1; ld_idx = idx; ld_val = v;
        tick;
        ld = 0;
    endtask

    task automatic test_reset;
        rst_n = 0; c_req = 1; d_req = 1;
        repeat (2) tick;
        n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        n_cmp++;
        if (dut.state_q !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
        n_cmp++;
        if (dut.wcnt_q !== '0) begin n_err++; $display("FAIL reset_wcnt: got %0d want 0", dut.wcnt_q); end
`ifdef DMEM_ARB_STATS_EN
        n_cmp++;
        if ({stat_c_cnt, stat_d_cnt, stat_force} !== '0) begin n_err++; $display("FAIL reset_stats: got %h want 0", {stat_c_cnt, stat_d_cnt, stat_force}); end
`endif
        c_req = 0; d_req = 0; rst_n = 1;
        tick;
    endtask

    task automatic test_cpu_read;
        apply_reset;
        preload(4'd4, 32'hDEADBEEF);
        c_req = 1; c_we = 0; c_addr = 32'h10;
        tick;
        n_cmp++;
        if ({c_gnt, d_gnt, m_en, m_we} !== 4'b1010) begin n_err++; $display("FAIL cpu_rd_gnt: got %b want 1010", {c_gnt, d_gnt, m_en, m_we}); end
        n_cmp++;
        if (m_addr !== 32'h10) begin n_err++; $display("FAIL cpu_rd_addr: got %h want 10", m_addr); end
        c_req = 0;
        tick;
        n_cmp++;
        if ({c_rvalid, d_rvalid, c_gnt} !== 3'b100) begin n_err++; $display("FAIL cpu_rd_rvalid: got %b want 100", {c_rvalid, d_rvalid, c_gnt}); end
        n_cmp++;
        if (c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_rd_data: got %h want deadbeef", c_rdata); end
        n_cmp++;
        if (d_rdata !== '0) begin n_err++; $display("FAIL cpu_rd_dside: got %h want 0", d_rdata); end
        tick;
        n_cmp++;
        if (c_rvalid !== 1'b0 || c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL cpu_rd_hold: got %b/%h want 0/deadbeef", c_rvalid, c_rdata); end
    endtask

    task automatic test_simultaneous;
        apply_reset;
        preload(4'd8, 32'hA1A1A1A1);
        preload(4'd9, 32'hB2B2B2B2);
        c_req = 1; c_we = 0; c_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h24; d_lock = 0;
        tick;
        n_cmp++;
        if ({c_gnt, d_gnt} !== 2'b10 || m_addr !== 32'h20) begin n_err++; $display("FAIL sim_first: got %b/%h want 10/20", {c_gnt, d_gnt}, m_addr); end
        c_req = 0;
        tick;
        n_cmp++;
        if ({c_gnt, d_gnt} !== 2'b01 || m_addr !== 32'h24) begin n_err++; $display("FAIL sim_second: got %b/%h want 01/24", {c_gnt, d_gnt}, m_addr); end
        n_cmp++;
        if ({c_rvalid, d_rvalid} !== 2'b10 || c_rdata !== 32'hA1A1A1A1) begin n_err++; $display("FAIL sim_c_ret: got %b/%h want 10/a1a1a1a1", {c_rvalid, d_rvalid}, c_rdata); end
        d_req = 0;
        tick;
        n_cmp++;
        if ({c_rvalid, d_rvalid} !== 2'b01 || d_rdata !== 32'hB2B2B2B2) begin n_err++; $display("FAIL sim_d_ret: got %b/%h want 01/b2b2b2b2", {c_rvalid, d_rvalid}, d_rdata); end
    endtask

    task automatic test_starvation;
        int cg = 0, dg = 0, dcyc = -1;
        apply_reset;
        c_req = 1; c_we = 1; c_addr = 32'h30; c_wdata = 32'h1234;
        d_req = 1; d_we = 0; d_addr = 32'h34; d_lock = 0;
        for (int k = 2; k <= 22; k++) begin
            tick;
            n_cmp++;
            if (c_gnt !== (k != 10 && k <= 21) || d_gnt !== (k == 10)) begin
                n_err++; $display("FAIL starve_c%0d: got c=%b d=%b want c=%b d=%b", k, c_gnt, d_gnt, k != 10 && k <= 21, k == 10);
            end
`ifdef DMEM_ARB_STATS_EN
            n_cmp++;
            if (stat_force !== (k == 10)) begin n_err++; $display("FAIL starve_force_c%0d: got %b want %b", k, stat_force, k == 10); end
`endif
            if (c_gnt) cg++;
            if (d_gnt) begin dg++; dcyc = k; d_req = 0; end
            if (k == 21) c_req = 0;
        end
        n_cmp++;
        if (cg != 19 || dg != 1 || dcyc != 10) begin n_err++; $display("FAIL starve_totals: got c=%0d d=%0d at %0d want 19/1/10", cg, dg, dcyc); end
`ifdef DMEM_ARB_STATS_EN
        n_cmp++;
        if (stat_c_cnt !== 32'd19 || stat_d_cnt !== 32'd1) begin n_err++; $display("FAIL starve_stats: got %0d/%0d want 19/1", stat_c_cnt, stat_d_cnt); end
`endif
    endtask

    task automatic test_lock;
        apply_reset;
        d_req = 1; d_lock = 1; d_we = 1; d_addr = 32'h0; d_wdata = 32'd1;
        c_we = 0; c_addr = 32'h3C;
        for (int k = 2; k <= 9; k++) begin
            tick;
            n_cmp++;
            if (d_gnt !== (k >= 2 && k <= 5) || c_gnt !== (k == 8)) begin
                n_err++; $display("FAIL lock_c%0d: got c=%b d=%b want c=%b d=%b", k, c_gnt, d_gnt, k == 8, k >= 2 && k <= 5);
            end
            if (d_gnt) begin
                n_cmp++;
                if (m_we !== 1'b1 || m_addr !== AW'((k - 2) * 4) || m_wdata !== DW'(k - 1)) begin
                    n_err++; $display("FAIL lock_beat%0d: got we=%b a=%h d=%h", k, m_we, m_addr, m_wdata);
                end
            end
            if (k <= 4) begin d_addr = AW'((k - 1) * 4); d_wdata = DW'(k); c_req = 1; end
            else if (k == 5) d_req = 0;
            else if (k == 6) d_lock = 0;
            else if (k == 8) c_req = 0;
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (mem[i] !== DW'(i + 1)) begin n_err++; $display("FAIL lock_mem%0d: got %h want %h", i, mem[i], i + 1); end
        end
    endtask

    task automatic test_reset_mid_read;
        apply_reset;
        preload(4'd5, 32'h5555AAAA);
        c_req = 1; c_we = 0; c_addr = 32'h14;
        tick;
        n_cmp++;
        if (c_gnt !== 1'b1) begin n_err++; $display("FAIL rstmid_gnt: got %b want 1", c_gnt); end
        c_req = 0; rst_n = 0;
        #1;
        n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL rstmid_async: got %h want 0", all_out); end
        tick; tick;
        rst_n = 1;
        for (int k = 0; k < 5; k++) begin
            tick;
            n_cmp++;
            if (all_out !== '0) begin n_err++; $display("FAIL rstmid_after%0d: got %h want 0", k, all_out); end
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin n_err++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state_q); end
    endtask

    task automatic test_random;
        logic [DW-1:0] gold [16];
        logic          lk, pend_v, pend_o, rv, ro, cw, dw, e_en, e_we, e_cg, e_dg, e_crv, e_drv, e_frc;
        logic [AW-1:0] a, e_addr;
        logic [DW-1:0] pend_d, rd, e_wd, e_crd, e_drd;
        int            wt, sc, sd;
        apply_reset;
        for (int i = 0; i < 16; i++) begin
            gold[i] = $urandom;
            preload(4'(i), gold[i]);
        end
        lk = 0; wt = 0; sc = 0; sd = 0; pend_v = 0; pend_o = 0; pend_d = '0;
        e_crd = '0; e_drd = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            // Who gets the memory this cycle, judged from the request rules alone.
            if (lk) begin cw = 0; dw = d_req; end
            else begin cw = c_req && !(wt == MAXW && d_req); dw = d_req && !cw; end
            e_frc = dw && c_req && !lk && wt == MAXW;
            rv = pend_v; ro = pend_o; rd = pend_d;
            a = dw ? d_addr : c_addr;
            e_en = cw || dw;
            e_we = dw ? d_we : c_we;
            e_wd = dw ? d_wdata : c_wdata;
            e_addr = a;
            pend_v = e_en && !e_we;
            pend_o = dw;
            pend_d = gold[a[5:2]];
            if (e_en && e_we) gold[a[5:2]] = e_wd;
            e_cg = cw; e_dg = dw;
            e_crv = rv && !ro; e_drv = rv && ro;
            if (e_crv) e_crd = rd;
            if (e_drv) e_drd = rd;
            if (dw) lk = d_lock;
            else if (!d_req && !d_lock) lk = 0;
            wt = (dw || !d_req) ? 0 : (cw && wt < MAXW) ? wt + 1 : wt;
            sc += int'(cw); sd += int'(dw);
            tick;
            n_cmp++;
            if ({c_gnt, d_gnt, m_en} !== {e_cg, e_dg, e_en}) begin
                n_err++; $display("FAIL rnd_gnt@%0d: got %b want %b", cyc, {c_gnt, d_gnt, m_en}, {e_cg, e_dg, e_en});
            end
            if (e_en) begin
                n_cmp++;
                if ({m_we, m_addr, m_wdata} !== {e_we, e_addr, e_wd}) begin
                    n_err++; $display("FAIL rnd_mem@%0d: got %b/%h/%h want %b/%h/%h", cyc, m_we, m_addr, m_wdata, e_we, e_addr, e_wd);
                end
            end
            n_cmp++;
            if ({c_rvalid, d_rvalid, c_rdata, d_rdata} !== {e_crv, e_drv, e_crd, e_drd}) begin
                n_err++; $display("FAIL rnd_ret@%0d: got %b%b/%h/%h want %b%b/%h/%h", cyc, c_rvalid, d_rvalid, c_rdata, d_rdata, e_crv, e_drv, e_crd, e_drd);
            end
`ifdef DMEM_ARB_STATS_EN
            n_cmp++;
            if (stat_force !== e_frc) begin n_err++; $display("FAIL rnd_force@%0d: got %b want %b", cyc, stat_force, e_frc); end
`endif
            if (!c_req || e_cg) begin
                c_req = ($urandom % 10) < 8;
                c_we = 1'($urandom % 2);
                c_addr = AW'($urandom_range(0, 15)) << 2;
                c_wdata = $urandom;
            end
            if (!d_req || e_dg) begin
                d_req = ($urandom % 10) < 4;
                d_we = 1'($urandom % 2);
                d_addr = AW'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
                d_lock = ($urandom % 4) == 0;
            end
        end
`ifdef DMEM_ARB_STATS_EN
        n_cmp++;
        if (stat_c_cnt !== 32'(sc) || stat_d_cnt !== 32'(sd)) begin n_err++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", stat_c_cnt, stat_d_cnt, sc, sd); end
`endif
        c_req = 0; d_req = 0; d_lock = 0;
        repeat (3) tick;
    endtask

    initial begin
        test_reset;
        test_cpu_read;
        test_simultaneous;
        test_starvation;
        test_lock;
        test_reset_mid_read;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single clocked data memory between two requesters: the CPU load/store stage (port 0) and a debug/program-loader port (port 1).
- Arbitrates one access per cycle and registers the winning request onto the memory interface.
- Routes the 1-cycle-latency read data back to the winner with a valid pulse.
- Supports a locked burst for the loader.
- Includes a starvation guard so the debug port is never blocked indefinitely by the CPU.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 8, consecutive cycles port 1 may wait while port 0 wins before port 1 is forced.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- c_req  in  1  CPU request; held until c_gnt
- c_we  in  1  CPU write enable
- c_addr  in  AW  CPU address
- c_wdata  in  DW  CPU write data
- c_gnt  out  1  CPU grant pulse
- c_rvalid  out  1  CPU read data valid pulse
- c_rdata  out  DW  CPU read data
- d_req  in  1  debug request; held until d_gnt
- d_lock  in  1  debug burst lock, sampled with d_req
- d_we  in  1  debug write enable
- d_addr  in  AW  debug address
- d_wdata  in  DW  debug write data
- d_gnt  out  1  debug grant pulse
- d_rvalid  out  1  debug read data valid pulse
- d_rdata  out  DW  debug read data
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, valid the cycle after m_en with m_we=0

Behaviour:
- Reset state:
  - All outputs 0.
  - FSM in IDLE.
  - Wait counter 0.
  - Read-tag pipeline cleared.
- FSM states: IDLE, CPU, DBG, DBG_LOCK. The state names the last winner.
- Arbitration is evaluated every cycle from the current req inputs; the winner is registered at the next edge.
- Winner rules when not in DBG_LOCK:
  - port 0 wins if c_req=1, unless the wait counter has reached MAX_WAIT;
  - otherwise port 1 wins if d_req=1;
  - otherwise there is no access and the next state is IDLE.
- Timing:
  - Request seen in cycle N.
  - Registered outputs in cycle N+1: m_en=1, m_we/m_addr/m_wdata copied from the winner, and the winner's gnt=1 for exactly one cycle.
  - For reads, winner's rvalid=1 in N+2 with rdata=m_rdata.
  - rdata is held until the next rvalid for that port.
- Back-to-back:
  - One grant per cycle maximum.
  - A requester whose req stays high after gnt is treated as a new request.
  - Requester must deassert req in the gnt cycle or change addr/we/wdata for the next transfer.
- Write accesses never produce rvalid.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle that d_req=1 and port 0 wins.
  - Clears when port 1 wins or d_req=0.
  - When the counter equals MAX_WAIT, port 1 wins once, then the counter clears.
- DBG_LOCK:
  - Entered when port 1 wins with d_lock=1.
  - While in DBG_LOCK, port 0 is never granted.
  - Port 1 is granted whenever d_req=1.
  - Exits to IDLE on the first cycle with d_lock=0 and d_req=0.
  - If d_lock=0 but d_req=1, the state stays DBG for that grant.
- Simultaneous c_req and d_req with the counter below MAX_WAIT: port 0 wins.
- A read-tag shift register tracks which port owns the in-flight read. A grant in cycle N+1 is tagged for return in N+2 regardless of later grants.
- Reset mid-operation: in-flight reads are discarded and no rvalid is emitted after reset release.

Optional Feature:
- Macro DMEM_ARB_STATS_EN adds outputs stat_c_cnt and stat_d_cnt, each 32 bits.
  - Each counts grants to its port and wraps at 2^32.
  - Both reset to 0.
  - Also adds output stat_force, 1 bit, which pulses in the same cycle as a starvation-forced d_gnt.
- Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, CPU, DBG, DBG_LOCK);
  - port index constants PORT_CPU=0 and PORT_DBG=1;
  - the default MAX_WAIT.
- One sub-module, dmem_arb_rtag: the 1-bit valid plus 1-bit owner read-tag pipeline, which generates the rvalid pulses and the rdata capture.

Test Plan:
- CPU read only: c_req with addr 0x10, memory holds 0xDEADBEEF -> c_gnt in cycle 2, m_addr=0x10 in cycle 2, c_rvalid=1 with c_rdata=0xDEADBEEF in cycle 3, d_* signals stay 0.
- Simultaneous c_req and d_req, both single reads, counter at 0 -> c_gnt first, d_gnt one cycle later (c_req dropped), each rvalid on its own port only.
- Starvation: c_req held high for 20 cycles with d_req high and MAX_WAIT=8 -> d_gnt exactly in cycle 10 (after 8 CPU grants), counter cleared, CPU grants resume.
- Locked burst: d_lock=1 with 4 debug writes (addrs 0,4,8,C, data 1..4) while c_req=1 -> four consecutive d_gnt, no c_gnt until d_lock=0 and d_req=0, then c_gnt.
- Reset mid-read: assert rst_n=0 in the cycle after c_gnt -> no c_rvalid at any time, all outputs 0, FSM IDLE after release.
- With DMEM_ARB_STATS_EN defined: run the starvation scenario -> stat_c_cnt=19, stat_d_cnt=1, and one stat_force pulse coincident with d_gnt.
